// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial A - B - Bin subtractor, LSB first, valid/ready on both sides
// Optional signed-overflow output Ovf is built when SERIAL_SUB_OVF_EN is defined.
module serial_subtractor #(
  parameter int WIDTH = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             In_Valid,
  output logic             In_Ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic             Out_Valid,
  input  logic             Out_Ready,
  output logic [WIDTH-1:0] Diff,
  output logic             Bout
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             Ovf
`endif
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state;
  state_t          state_nxt;

  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic             br;
  logic [CW-1:0]    cnt;

`ifdef SERIAL_SUB_OVF_EN
  logic             sa;
  logic             sb;
`endif

  logic             a_bit;
  logic             b_bit;
  logic             d_bit;
  logic             br_nxt;
  logic             last_bit;
  logic             accept;

  assign a_bit    = a_sh[0];
  assign b_bit    = b_sh[0];
  assign d_bit    = a_bit ^ b_bit ^ br;
  assign br_nxt   = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & br);
  assign last_bit = (cnt == CW'(WIDTH - 1));
  assign accept   = In_Valid & In_Ready;

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // In_Ready is gated by RST so the block never advertises readiness while held in reset.
  always_comb begin
    state_nxt = state;
    In_Ready  = 1'b0;
    Out_Valid = 1'b0;
    case (state)
      IDLE: begin
        In_Ready = RST;
        if (In_Valid) begin
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (last_bit) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        Out_Valid = 1'b1;
        if (Out_Ready) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      a_sh <= '0;
      b_sh <= '0;
      br   <= 1'b0;
      cnt  <= '0;
      Diff <= '0;
      Bout <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      sa   <= 1'b0;
      sb   <= 1'b0;
      Ovf  <= 1'b0;
`endif
    end else begin
      if (state == IDLE && accept) begin
        a_sh <= A;
        b_sh <= B;
        br   <= Bin;
        cnt  <= '0;
`ifdef SERIAL_SUB_OVF_EN
        sa   <= A[WIDTH-1];
        sb   <= B[WIDTH-1];
`endif
      end else if (state == RUN) begin
        a_sh <= {1'b0, a_sh[WIDTH-1:1]};
        b_sh <= {1'b0, b_sh[WIDTH-1:1]};
        br   <= br_nxt;
        Diff <= {d_bit, Diff[WIDTH-1:1]};
        cnt  <= cnt + CW'(1);
        // Bout is a separate register so it holds the completed result while br churns.
        if (last_bit) begin
          Bout <= br_nxt;
`ifdef SERIAL_SUB_OVF_EN
          Ovf  <= (sa ^ sb) & (sa ^ d_bit);
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - randomized and directed self-checking bench for serial_subtractor
// Build with SERIAL_SUB_OVF_EN defined to also check the Ovf output.
module tb_serial_subtractor;

  localparam int W = 16;

  logic         CLK;
  logic         RST;
  logic         In_Valid;
  logic         In_Ready;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         Bin;
  logic         Out_Valid;
  logic         Out_Ready;
  logic [W-1:0] Diff;
  logic         Bout;
`ifdef SERIAL_SUB_OVF_EN
  logic         Ovf;
`endif

  int vectors = 0;
  int errors  = 0;

  serial_subtractor #(.WIDTH(W)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .In_Valid  (In_Valid),
    .In_Ready  (In_Ready),
    .A         (A),
    .B         (B),
    .Bin       (Bin),
    .Out_Valid (Out_Valid),
    .Out_Ready (Out_Ready),
    .Diff      (Diff),
    .Bout      (Bout)
`ifdef SERIAL_SUB_OVF_EN
    ,
    .Ovf       (Ovf)
`endif
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  function automatic logic [W-1:0] ref_diff(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic bin);
    return a - b - W'(bin);
  endfunction

  function automatic logic ref_bout(input logic [W-1:0] a, input logic [W-1:0] b,
                                    input logic bin);
    longint ia, ib;
    ia = longint'(a);
    ib = longint'(b) + longint'(bin);
    return ia < ib;
  endfunction

  function automatic logic ref_ovf(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic bin);
    logic [W-1:0] d;
    d = ref_diff(a, b, bin);
    return (a[W-1] ^ b[W-1]) & (a[W-1] ^ d[W-1]);
  endfunction

  // Drives one operation; hold = cycles Out_Ready stays low after Out_Valid, poke = offer
  // other operands during the hold. stable reports outputs frozen and In_Ready low during hold.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin,
                       input int hold, input bit poke,
                       output int lat, output logic [W-1:0] d, output logic bo,
                       output logic ov, output logic rdy_after, output logic stable);
    int guard;
    Out_Ready = (hold == 0);
    A = a; B = b; Bin = bin; In_Valid = 1'b1;
    guard = 0;
    while (!In_Ready && guard < 100) begin
      @(posedge CLK); #1;
      guard++;
    end
    @(posedge CLK); #1;
    In_Valid = 1'b0;
    lat = 0;
    while (!Out_Valid && lat < 4 * W) begin
      @(posedge CLK); #1;
      lat++;
    end
    d  = Diff;
    bo = Bout;
`ifdef SERIAL_SUB_OVF_EN
    ov = Ovf;
`else
    ov = 1'b0;
`endif
    stable = 1'b1;
    for (int i = 0; i < hold; i++) begin
      if (poke) begin
        In_Valid = 1'b1; A = ~a; B = ~b; Bin = ~bin;
      end
      @(posedge CLK); #1;
      if (Diff !== d || Bout !== bo || Out_Valid !== 1'b1 || In_Ready !== 1'b0) stable = 1'b0;
    end
    In_Valid = 1'b0;
    Out_Ready = 1'b1;
    @(posedge CLK); #1;
    rdy_after = In_Ready && !Out_Valid;
  endtask

  task automatic test_reset();
    RST = 1'b0; In_Valid = 1'b0; Out_Ready = 1'b1; A = '0; B = '0; Bin = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    vectors++;
    if (Out_Valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", Out_Valid); end
    vectors++;
    if (Diff !== '0) begin errors++; $display("FAIL reset_diff got %h want 0000", Diff); end
    vectors++;
    if (Bout !== 1'b0) begin errors++; $display("FAIL reset_bout got %b want 0", Bout); end
    vectors++;
    if (In_Ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %b want 0", In_Ready); end
`ifdef SERIAL_SUB_OVF_EN
    vectors++;
    if (Ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b want 0", Ovf); end
`endif
    RST = 1'b1;
    @(posedge CLK); #1;
    vectors++;
    if (In_Ready !== 1'b1) begin errors++; $display("FAIL release_in_ready got %b want 1", In_Ready); end
  endtask

  task automatic test_basic();
    int lat; logic [W-1:0] d; logic bo, ov, rdy, st;
    do_op(16'h1234, 16'h0034, 1'b0, 0, 1'b0, lat, d, bo, ov, rdy, st);
    vectors++;
    if (lat !== W) begin errors++; $display("FAIL basic_latency got %0d want %0d", lat, W); end
    vectors++;
    if (d !== 16'h1200) begin errors++; $display("FAIL basic_diff got %h want 1200", d); end
    vectors++;
    if (bo !== 1'b0) begin errors++; $display("FAIL basic_bout got %b want 0", bo); end
    vectors++;
    if (rdy !== 1'b1) begin errors++; $display("FAIL basic_ready_after got %b want 1", rdy); end
  endtask

  task automatic test_borrow_wrap();
    int lat; logic [W-1:0] d; logic bo, ov, rdy, st;
    do_op(16'h0000, 16'h0001, 1'b0, 0, 1'b0, lat, d, bo, ov, rdy, st);
    vectors++;
    if (d !== 16'hFFFF || bo !== 1'b1) begin
      errors++; $display("FAIL wrap_0_minus_1 got %h/%b want ffff/1", d, bo);
    end
    do_op(16'hFFFF, 16'hFFFF, 1'b1, 0, 1'b0, lat, d, bo, ov, rdy, st);
    vectors++;
    if (d !== 16'hFFFF || bo !== 1'b1) begin
      errors++; $display("FAIL wrap_ffff_ffff_bin got %h/%b want ffff/1", d, bo);
    end
  endtask

  task automatic test_borrow_in();
    int lat; logic [W-1:0] d; logic bo, ov, rdy, st;
    do_op(16'h0005, 16'h0003, 1'b1, 0, 1'b0, lat, d, bo, ov, rdy, st);
    vectors++;
    if (d !== 16'h0001 || bo !== 1'b0) begin
      errors++; $display("FAIL borrow_in got %h/%b want 0001/0", d, bo);
    end
  endtask

  task automatic test_backpressure();
    int lat; logic [W-1:0] d; logic bo, ov, rdy, st;
    do_op(16'h00FF, 16'h000F, 1'b0, 5, 1'b1, lat, d, bo, ov, rdy, st);
    vectors++;
    if (d !== 16'h00F0) begin errors++; $display("FAIL bp_diff got %h want 00f0", d); end
    vectors++;
    if (st !== 1'b1) begin errors++; $display("FAIL bp_frozen got %b want 1", st); end
    vectors++;
    if (rdy !== 1'b1) begin errors++; $display("FAIL bp_ready_after got %b want 1", rdy); end
    vectors++;
    if (Diff !== 16'h00F0) begin errors++; $display("FAIL bp_idle_hold got %h want 00f0", Diff); end
  endtask

  task automatic test_reset_mid_run();
    int lat, pulses; logic [W-1:0] d; logic bo, ov, rdy, st;
    A = 16'hAAAA; B = 16'h5555; Bin = 1'b0; In_Valid = 1'b1;
    vectors++;
    if (In_Ready !== 1'b1) begin errors++; $display("FAIL midrst_pre_ready got %b want 1", In_Ready); end
    @(posedge CLK); #1;
    In_Valid = 1'b0;
    repeat (7) @(posedge CLK);
    #1;
    RST = 1'b0;
    vectors++;
    if (In_Ready !== 1'b0) begin errors++; $display("FAIL midrst_ready_low got %b want 0", In_Ready); end
    @(posedge CLK); #1;
    vectors++;
    if (Out_Valid !== 1'b0 || Diff !== '0 || Bout !== 1'b0 || In_Ready !== 1'b0) begin
      errors++;
      $display("FAIL midrst_cleared got ov=%b diff=%h bout=%b rdy=%b want 0/0000/0/0",
               Out_Valid, Diff, Bout, In_Ready);
    end
    RST = 1'b1;
    pulses = 0;
    for (int i = 0; i < W + 4; i++) begin
      @(posedge CLK); #1;
      if (Out_Valid) pulses++;
    end
    vectors++;
    if (pulses != 0) begin errors++; $display("FAIL midrst_no_pulse got %0d want 0", pulses); end
    do_op(16'h0010, 16'h0001, 1'b0, 0, 1'b0, lat, d, bo, ov, rdy, st);
    vectors++;
    if (d !== 16'h000F || bo !== 1'b0) begin
      errors++; $display("FAIL midrst_next_op got %h/%b want 000f/0", d, bo);
    end
  endtask

  task automatic test_random();
    int lat; logic [W-1:0] d; logic bo, ov, rdy, st;
    logic [W-1:0] a, b; logic bin; int hold;
    for (int n = 0; n < 24; n++) begin
      a = W'($urandom); b = W'($urandom); bin = 1'($urandom_range(0, 1));
      hold = $urandom_range(0, 3);
      do_op(a, b, bin, hold, 1'b0, lat, d, bo, ov, rdy, st);
      vectors++;
      if (d !== ref_diff(a, b, bin) || bo !== ref_bout(a, b, bin)) begin
        errors++;
        $display("FAIL rand_result a=%h b=%h bin=%b got %h/%b want %h/%b",
                 a, b, bin, d, bo, ref_diff(a, b, bin), ref_bout(a, b, bin));
      end
      vectors++;
      if (lat !== W || st !== 1'b1 || rdy !== 1'b1) begin
        errors++;
        $display("FAIL rand_timing got lat=%0d stable=%b rdy=%b want %0d/1/1", lat, st, rdy, W);
      end
`ifdef SERIAL_SUB_OVF_EN
      vectors++;
      if (ov !== ref_ovf(a, b, bin)) begin
        errors++; $display("FAIL rand_ovf a=%h b=%h got %b want %b", a, b, ov, ref_ovf(a, b, bin));
      end
`endif
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] ed[$]; logic eb[$];
    logic [W-1:0] a, b, ex_d; logic bin, ex_b; bit acc;
    int last, n_acc, n_out;
    a = W'($urandom); b = W'($urandom); bin = 1'($urandom_range(0, 1));
    A = a; B = b; Bin = bin; In_Valid = 1'b1; Out_Ready = 1'b1;
    last = -1; n_acc = 0; n_out = 0;
    for (int cyc = 0; cyc < 6 * (W + 2); cyc++) begin
      if (Out_Valid) begin
        vectors++;
        if (ed.size() == 0) begin
          errors++; $display("FAIL b2b_spurious_valid got 1 want 0");
        end else begin
          ex_d = ed.pop_front(); ex_b = eb.pop_front(); n_out++;
          if (Diff !== ex_d || Bout !== ex_b) begin
            errors++; $display("FAIL b2b_result got %h/%b want %h/%b", Diff, Bout, ex_d, ex_b);
          end
        end
      end
      acc = In_Ready && In_Valid;
      if (acc) begin
        if (last >= 0) begin
          vectors++;
          if (cyc - last != W + 2) begin
            errors++; $display("FAIL b2b_spacing got %0d want %0d", cyc - last, W + 2);
          end
        end
        last = cyc;
        ed.push_back(ref_diff(a, b, bin));
        eb.push_back(ref_bout(a, b, bin));
        n_acc++;
      end
      @(posedge CLK); #1;
      if (acc) begin
        if (n_acc == 4) begin
          In_Valid = 1'b0;
        end else begin
          a = W'($urandom); b = W'($urandom); bin = 1'($urandom_range(0, 1));
          A = a; B = b; Bin = bin;
        end
      end
    end
    In_Valid = 1'b0;
    vectors++;
    if (n_out != 4) begin errors++; $display("FAIL b2b_count got %0d want 4", n_out); end
  endtask

`ifdef SERIAL_SUB_OVF_EN
  task automatic test_ovf();
    int lat; logic [W-1:0] d; logic bo, ov, rdy, st;
    do_op(16'h8000, 16'h0001, 1'b0, 0, 1'b0, lat, d, bo, ov, rdy, st);
    vectors++;
    if (d !== 16'h7FFF || ov !== 1'b1 || bo !== 1'b0) begin
      errors++; $display("FAIL ovf_set got %h/%b/%b want 7fff/1/0", d, ov, bo);
    end
    do_op(16'h0003, 16'h0001, 1'b0, 0, 1'b0, lat, d, bo, ov, rdy, st);
    vectors++;
    if (ov !== 1'b0) begin errors++; $display("FAIL ovf_clear got %b want 0", ov); end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_borrow_wrap();
    test_borrow_in();
    test_backpressure();
    test_reset_mid_run();
`ifdef SERIAL_SUB_OVF_EN
    test_ovf();
`endif
    test_random();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Bit-serial two's-complement subtractor. It computes A − B − Bin one bit per clock, LSB first. It is the sequential, area-minimal counterpart of the 16-bit combinational ripple adder in the arithmetic lab set. Operands enter through a valid/ready handshake and the registered difference leaves through a second valid/ready handshake, so the block drops straight into a pipelined datapath for synthesis comparison against the combinational adders.

## Interface

Parameters:
- WIDTH, 16, operand and result width in bits; legal range 2..64.

Ports:
- CLK  input  1  single clock; all logic is rising-edge.
- RST  input  1  synchronous, active-low reset.
- In_Valid  input  1  operands on A/B/Bin are valid.
- In_Ready  output  1  block accepts operands this cycle.
- A  input  WIDTH  minuend.
- B  input  WIDTH  subtrahend.
- Bin  input  1  borrow-in.
- Out_Valid  output  1  Diff/Bout hold a completed result.
- Out_Ready  input  1  downstream consumes the result.
- Diff  output  WIDTH  A − B − Bin, modulo 2^WIDTH.
- Bout  output  1  borrow-out; 1 when A < B + Bin as unsigned values.
- Ovf  output  1  signed overflow; present only with SERIAL_SUB_OVF_EN.

One clock; reset is synchronous and active-low.

## Operation

- FSM states are IDLE, RUN and DONE.
- IDLE:
  - In_Ready = 1.
  - On In_Valid & In_Ready: capture A and B into shift registers, borrow register ← Bin, bit counter ← 0, and store sign bits A[WIDTH−1] and B[WIDTH−1]. Go to RUN.
- RUN: once per cycle, with a = A_sh[0], b = B_sh[0] and br = borrow register:
  - d = a ^ b ^ br.
  - borrow ← (~a & b) | (~(a ^ b) & br).
  - Shift A_sh and B_sh right by 1.
  - Shift d into Diff at the MSB end (Diff ← {d, Diff[WIDTH−1:1]}).
  - Increment the counter.
  - When the counter reaches WIDTH−1, this cycle processes the last bit: go to DONE.
- DONE:
  - Out_Valid = 1 and Bout = final borrow.
  - Diff and Bout hold stable.
  - On Out_Ready, go to IDLE.
- In_Ready is 0 in RUN and DONE. In_Valid is ignored there.
- Out_Valid is 0 in IDLE and RUN.
- Diff and Bout keep their last completed value in IDLE.
  - Diff changes during RUN. Consumers sample it only while Out_Valid = 1.
- Arithmetic is unsigned modulo 2^WIDTH. Bout is the borrow out of bit WIDTH−1.
- Out_Valid never depends combinationally on Out_Ready.

## Timing

- Reset, applied at a rising edge with RST = 0:
  - State = IDLE.
  - Diff = 0, Bout = 0, Out_Valid = 0, Ovf = 0.
  - Counter = 0, shift registers = 0.
- In_Ready = 0 whenever RST = 0. It is 1 from the first cycle after reset is released.
- Reset during RUN or DONE aborts the operation. No Out_Valid pulse occurs and the result is discarded.
- Latency:
  - Operands accepted at edge k.
  - Out_Valid = 1 after edge k+WIDTH.
  - Example: 16 cycles for WIDTH = 16.
- Output handshake at edge m (Out_Valid & Out_Ready): the FSM is in IDLE after m, and In_Ready = 1 in that cycle.
- Back-to-back throughput is therefore one operation per WIDTH+2 cycles with Out_Ready held at 1.
- Out_Ready held low: DONE persists indefinitely with outputs frozen.

## Configuration

- SERIAL_SUB_OVF_EN defined:
  - The Ovf port exists.
  - Ovf is registered on entry to DONE as (sA ^ sB) & (sA ^ Diff[WIDTH−1]), where sA and sB are the captured sign bits.
  - Ovf is valid with Out_Valid, held until the next DONE entry, and reset to 0.
- SERIAL_SUB_OVF_EN undefined:
  - No Ovf port.
  - No sign-bit storage.
  - All other behaviour is identical.

## Test plan

- Basic: A=0x1234, B=0x0034, Bin=0, Out_Ready=1.
  - Out_Valid rises exactly 16 cycles after acceptance.
  - Diff=0x1200, Bout=0.
- Borrow wrap: A=0x0000, B=0x0001, Bin=0.
  - Diff=0xFFFF, Bout=1.
  - Next op A=0xFFFF, B=0xFFFF, Bin=1: Diff=0xFFFF, Bout=1.
- Borrow-in: A=0x0005, B=0x0003, Bin=1.
  - Diff=0x0001, Bout=0.
- Backpressure: A=0x00FF, B=0x000F with Out_Ready held 0 for 5 cycles after Out_Valid.
  - Diff=0x00F0 is stable throughout the 5 cycles.
  - In_Ready stays 0, and a concurrent In_Valid with new operands is ignored.
  - After Out_Ready=1, In_Ready=1 on the next cycle.
- Reset mid-run: assert RST=0 eight cycles after accepting A=0xAAAA, B=0x5555.
  - Next cycle: Out_Valid=0, Diff=0, Bout=0, and In_Ready=0 while RST=0.
  - After release, a new op A=0x0010, B=0x0001 yields Diff=0x000F.
- Overflow (SERIAL_SUB_OVF_EN):
  - A=0x8000, B=0x0001: Diff=0x7FFF, Ovf=1, Bout=0.
  - A=0x0003, B=0x0001: Ovf=0.
